// File: rtl/irq_injector_if.sv
// irq_injector_if: CPU observation, trigger configuration and interrupt output bundle
interface irq_injector_if #(parameter int NUM_CH = 6, parameter int NUM_TRIG = 4);
   logic [31:0] macroscopic_pc;
   logic [31:0] m_data_addr;
   logic [3:0] m_data_byteen;
   logic cfg_we;
   logic [$clog2(NUM_TRIG)-1:0] cfg_idx;
   logic [31:0] cfg_pc;
   logic [$clog2(NUM_CH)-1:0] cfg_ch;
   logic [7:0] cfg_delay;
   logic [7:0] cfg_count;
   logic [NUM_CH-1:0] irq;
   logic busy;
   logic [15:0] fire_count;
   logic timeout;
   modport master (
      output macroscopic_pc, m_data_addr, m_data_byteen,
      output cfg_we, cfg_idx, cfg_pc, cfg_ch, cfg_delay, cfg_count,
      input irq, busy, fire_count, timeout
   );
   modport slave (
      input macroscopic_pc, m_data_addr, m_data_byteen,
      input cfg_we, cfg_idx, cfg_pc, cfg_ch, cfg_delay, cfg_count,
      output irq, busy, fire_count, timeout
   );
endinterface

// File: rtl/irq_injector.sv
// irq_injector: PC-triggered interrupt stimulus engine with a programmable trigger table
module irq_injector #(
   parameter int NUM_CH = 6,
   parameter int NUM_TRIG = 4,
   parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
   parameter int MAX_HOLD = 1024
) (
   input logic clk,
   input logic reset,
   irq_injector_if.slave bus
);
   localparam int IW = $clog2(NUM_TRIG);
   localparam int CW = $clog2(NUM_CH);
   localparam int HW = $clog2(MAX_HOLD + 1);
   typedef enum logic [1:0] {IDLE, DELAY, ASSERT} state_t;
   state_t state;
   logic [31:0] t_pc [NUM_TRIG];
   logic [CW-1:0] t_ch [NUM_TRIG];
   logic [7:0] t_delay [NUM_TRIG];
   logic [7:0] t_count [NUM_TRIG];
   logic [31:0] pc, last_pc;
   logic [CW-1:0] ch;
   logic [7:0] dly;
   logic [HW-1:0] hold;
   logic hit, ack;
   logic [IW-1:0] sel;
   assign pc = bus.macroscopic_pc & ~32'd3;
   // an out-of-range channel drives no line, so only the hold timeout can release it
   assign ack = |bus.m_data_byteen && (bus.m_data_addr & ~32'd3) == ACK_ADDR && 32'(ch) < NUM_CH;
   assign bus.busy = state != IDLE;
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_TRIG - 1; i >= 0; i--)
         if (t_count[i] != 8'd0 && (t_pc[i] & ~32'd3) == pc && pc != last_pc) begin
            hit = 1'b1;
            sel = IW'(i);
         end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         bus.irq <= '0;
         bus.fire_count <= '0;
         bus.timeout <= 1'b0;
         last_pc <= '1;
         ch <= '0;
         dly <= '0;
         hold <= '0;
         for (int i = 0; i < NUM_TRIG; i++) begin
            t_pc[i] <= '0;
            t_ch[i] <= '0;
            t_delay[i] <= '0;
            t_count[i] <= '0;
         end
      end else begin
         case (state)
            IDLE:
               if (hit) begin
                  t_count[sel] <= t_count[sel] - 8'd1;
                  ch <= t_ch[sel];
                  dly <= t_delay[sel];
                  last_pc <= pc;
                  hold <= '0;
                  state <= t_delay[sel] == 8'd0 ? ASSERT : DELAY;
                  bus.irq <= t_delay[sel] == 8'd0 ? NUM_CH'(1) << t_ch[sel] : '0;
               end else if (pc != last_pc) last_pc <= '1;
            DELAY:
               if (dly == 8'd1) begin
                  state <= ASSERT;
                  bus.irq <= NUM_CH'(1) << ch;
               end else dly <= dly - 8'd1;
            ASSERT:
               if (ack || hold == HW'(MAX_HOLD - 1)) begin
                  state <= IDLE;
                  bus.irq <= '0;
                  if (ack) bus.fire_count <= bus.fire_count + 16'(bus.fire_count != 16'hFFFF);
                  else bus.timeout <= 1'b1;
               end else hold <= hold + 1'b1;
            default: state <= IDLE;
         endcase
         if (bus.cfg_we) begin
            t_pc[bus.cfg_idx] <= bus.cfg_pc;
            t_ch[bus.cfg_idx] <= bus.cfg_ch;
            t_delay[bus.cfg_idx] <= bus.cfg_delay;
            t_count[bus.cfg_idx] <= bus.cfg_count;
         end
      end
   end
endmodule

// File: tb/tb_irq_injector.sv
// tb_irq_injector: directed checks of trigger matching, delay, ack, timeout and reset
module tb_irq_injector;
   logic clk, reset;
   int checks = 0, errors = 0;
   irq_injector_if #(.NUM_CH(6), .NUM_TRIG(4)) bus ();
   irq_injector #(.NUM_CH(6), .NUM_TRIG(4), .ACK_ADDR(32'h0000_7F20), .MAX_HOLD(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cfg(input int idx, input logic [31:0] pc, input int ch, input int dly, input int cnt);
      bus.cfg_we = 1'b1;
      bus.cfg_idx = 2'(idx);
      bus.cfg_pc = pc;
      bus.cfg_ch = 3'(ch);
      bus.cfg_delay = 8'(dly);
      bus.cfg_count = 8'(cnt);
      step();
      bus.cfg_we = 1'b0;
   endtask
   task automatic ack(input logic [31:0] addr);
      bus.m_data_addr = addr;
      bus.m_data_byteen = 4'hF;
   endtask
   initial begin
      reset = 1'b1;
      bus.macroscopic_pc = 32'h3000;
      bus.m_data_addr = 32'h0;
      bus.m_data_byteen = 4'h0;
      bus.cfg_we = 1'b0;
      bus.cfg_idx = '0;
      bus.cfg_pc = '0;
      bus.cfg_ch = '0;
      bus.cfg_delay = '0;
      bus.cfg_count = '0;
      step();
      step();
      chk("rst_irq", 32'(bus.irq), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_fc", 32'(bus.fire_count), 32'h0);
      chk("rst_to", 32'(bus.timeout), 32'h0);
      reset = 1'b0;
      step();
      // single shot, zero delay
      cfg(0, 32'h3018, 2, 0, 1);
      chk("cfg_idle", 32'(bus.busy), 32'h0);
      bus.macroscopic_pc = 32'h3018;
      step();
      chk("t1_irq", 32'(bus.irq), 32'h04);
      chk("t1_busy", 32'(bus.busy), 32'h1);
      bus.macroscopic_pc = 32'h301C;
      step();
      chk("t1_hold", 32'(bus.irq), 32'h04);
      ack(32'h7F20);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t1_ack_irq", 32'(bus.irq), 32'h0);
      chk("t1_fc", 32'(bus.fire_count), 32'h1);
      chk("t1_idle", 32'(bus.busy), 32'h0);
      bus.macroscopic_pc = 32'h3018;
      step();
      step();
      chk("t1_revisit", 32'(bus.irq), 32'h0);
      chk("t1_revisit_busy", 32'(bus.busy), 32'h0);
      // delayed firing
      bus.macroscopic_pc = 32'h3000;
      step();
      cfg(0, 32'h3018, 0, 5, 1);
      bus.macroscopic_pc = 32'h3018;
      step();
      chk("t2_busy", 32'(bus.busy), 32'h1);
      chk("t2_irq_t1", 32'(bus.irq), 32'h0);
      bus.macroscopic_pc = 32'h3000;
      step();
      step();
      step();
      step();
      chk("t2_irq_t5", 32'(bus.irq), 32'h0);
      step();
      chk("t2_irq_t6", 32'(bus.irq), 32'h01);
      ack(32'h7F22);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t2_ack_irq", 32'(bus.irq), 32'h0);
      chk("t2_fc", 32'(bus.fire_count), 32'h2);
      // repeat count, PC held across ack
      cfg(1, 32'h3040, 3, 0, 3);
      bus.macroscopic_pc = 32'h3040;
      step();
      chk("t3_fire1", 32'(bus.irq), 32'h08);
      ack(32'h7F20);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t3_ack1", 32'(bus.irq), 32'h0);
      step();
      step();
      chk("t3_held_irq", 32'(bus.irq), 32'h0);
      chk("t3_held_busy", 32'(bus.busy), 32'h0);
      bus.macroscopic_pc = 32'h3000;
      step();
      for (int k = 0; k < 2; k++) begin
         bus.macroscopic_pc = 32'h3040;
         step();
         chk("t3_fire", 32'(bus.irq), 32'h08);
         bus.macroscopic_pc = 32'h3000;
         ack(32'h7F20);
         step();
         bus.m_data_byteen = 4'h0;
         chk("t3_ack", 32'(bus.irq), 32'h0);
         step();
      end
      chk("t3_fc", 32'(bus.fire_count), 32'h5);
      bus.macroscopic_pc = 32'h3040;
      step();
      step();
      chk("t3_fourth", 32'(bus.irq), 32'h0);
      chk("t3_fourth_busy", 32'(bus.busy), 32'h0);
      bus.macroscopic_pc = 32'h3000;
      step();
      // priority: lowest index wins, other fires on next visit
      cfg(0, 32'h3020, 1, 0, 1);
      cfg(2, 32'h3020, 4, 0, 1);
      bus.macroscopic_pc = 32'h3020;
      step();
      chk("t4_prio", 32'(bus.irq), 32'h02);
      bus.macroscopic_pc = 32'h3000;
      ack(32'h7F20);
      step();
      bus.m_data_byteen = 4'h0;
      step();
      bus.macroscopic_pc = 32'h3020;
      step();
      chk("t4_second", 32'(bus.irq), 32'h10);
      bus.macroscopic_pc = 32'h3000;
      ack(32'h7F20);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t4_fc", 32'(bus.fire_count), 32'h7);
      // hold timeout; store to a neighbouring word is not an ack
      cfg(3, 32'h3050, 5, 0, 1);
      bus.macroscopic_pc = 32'h3050;
      step();
      chk("t5_irq", 32'(bus.irq), 32'h20);
      bus.macroscopic_pc = 32'h3000;
      ack(32'h7F24);
      for (int k = 0; k < 7; k++) step();
      chk("t5_irq_c8", 32'(bus.irq), 32'h20);
      chk("t5_to_c8", 32'(bus.timeout), 32'h0);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t5_drop", 32'(bus.irq), 32'h0);
      chk("t5_to", 32'(bus.timeout), 32'h1);
      chk("t5_fc", 32'(bus.fire_count), 32'h7);
      chk("t5_idle", 32'(bus.busy), 32'h0);
      // out-of-range channel: no line, ack ignored, timeout releases
      cfg(3, 32'h3060, 7, 0, 1);
      bus.macroscopic_pc = 32'h3060;
      step();
      chk("t6_busy", 32'(bus.busy), 32'h1);
      chk("t6_irq", 32'(bus.irq), 32'h0);
      bus.macroscopic_pc = 32'h3000;
      ack(32'h7F20);
      step();
      bus.m_data_byteen = 4'h0;
      chk("t6_noack", 32'(bus.busy), 32'h1);
      for (int k = 0; k < 7; k++) step();
      chk("t6_release", 32'(bus.busy), 32'h0);
      chk("t6_fc", 32'(bus.fire_count), 32'h7);
      // reset during ASSERT clears the table
      cfg(0, 32'h3018, 2, 0, 2);
      bus.macroscopic_pc = 32'h3018;
      step();
      chk("t7_irq", 32'(bus.irq), 32'h04);
      reset = 1'b1;
      step();
      chk("t7_rst_irq", 32'(bus.irq), 32'h0);
      chk("t7_rst_busy", 32'(bus.busy), 32'h0);
      chk("t7_rst_fc", 32'(bus.fire_count), 32'h0);
      chk("t7_rst_to", 32'(bus.timeout), 32'h0);
      reset = 1'b0;
      bus.macroscopic_pc = 32'h3000;
      step();
      bus.macroscopic_pc = 32'h3018;
      step();
      step();
      chk("t7_cleared_irq", 32'(bus.irq), 32'h0);
      chk("t7_cleared_busy", 32'(bus.busy), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
